// File: rtl/sad_pkg.sv
// Shared definitions for the SAD datapath and its neighbours (pixel fetch,
// motion-search comparator).
//   clog2    : ceiling log2 for deriving widths from parameters
//   *_DEF    : default pixel width, lane count and block length
//   lane_lo  : LSB index of lane i in a packed LANES*PIX_W pixel bus, so
//              every block packs and unpacks lanes identically
package sad_pkg;

  localparam int PIX_W_DEF     = 8;
  localparam int LANES_DEF     = 8;
  localparam int MAX_BEATS_DEF = 256;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction

  function automatic int lane_lo(input int lane, input int w);
    return lane * w;
  endfunction

endpackage

// File: rtl/sad_csa_4_2_row.sv
// csa_4_2_cell : single-bit 4:2 compressor, built from two full adders.
//   x1..x4, cin -> sum (weight 1), carry and cout (weight 2).
// csa_4_2_row  : W cells with cout of cell i feeding cin of cell i+1; the
//   chain enters at bit 0 as 0.
//   x1..x4 [W-1:0] -> sum [W-1:0], carry [W-1:0] (already shifted left by
//   one), with sum + carry == x1 + x2 + x3 + x4 modulo 2^W.
module csa_4_2_cell (
  input  logic x1,
  input  logic x2,
  input  logic x3,
  input  logic x4,
  input  logic cin,
  output logic sum,
  output logic carry,
  output logic cout
);
  logic s1;
  assign s1    = x1 ^ x2 ^ x3;
  assign cout  = (x1 & x2) | (x1 & x3) | (x2 & x3);
  assign sum   = s1 ^ x4 ^ cin;
  assign carry = (s1 & x4) | (s1 & cin) | (x4 & cin);
endmodule

module csa_4_2_row #(
  parameter int W = 8
) (
  input  logic [W-1:0] x1,
  input  logic [W-1:0] x2,
  input  logic [W-1:0] x3,
  input  logic [W-1:0] x4,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);
  logic [W:0]   chain;
  logic [W-1:0] carry_raw;
  // Top carry bits weigh 2^W; callers size W so the true sum never reaches
  // them, which makes discarding them exact.
  logic         unused_top;

  assign chain[0] = 1'b0;

  for (genvar i = 0; i < W; i++) begin : g_cell
    csa_4_2_cell u_cell (
      .x1   (x1[i]),
      .x2   (x2[i]),
      .x3   (x3[i]),
      .x4   (x4[i]),
      .cin  (chain[i]),
      .sum  (sum[i]),
      .carry(carry_raw[i]),
      .cout (chain[i+1])
    );
  end

  assign carry      = {carry_raw[W-2:0], 1'b0};
  assign unused_top = chain[W] ^ carry_raw[W-1];
endmodule

// File: rtl/sad_csa_accum_pipe.sv
// Pipelined sum-of-absolute-differences engine for block matching.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : beat handshake; in_last marks a block's final beat
//   a_pix, b_pix        : LANES unsigned pixels each, lane i at [i*PIX_W +: PIX_W]
//   sad_valid/sad_ready : result handshake
//   sad_out             : block SAD
//   sad_ovf             : block was cut at MAX_BEATS without in_last
// Handshakes: a transfer happens on a rising edge where valid && ready. A
// valid result holds sad_out/sad_ovf stable until it transfers; while it is
// refused every pipeline register freezes and in_ready drops.
// Stages: S0 input capture, S1 |a-b|, S2 4:2 tree, S3 carry-save accumulate,
// S4 carry-propagate add into the result register.
module sad_csa_accum_pipe import sad_pkg::*; #(
  parameter  int PIX_W     = PIX_W_DEF,
  parameter  int LANES     = LANES_DEF,
  parameter  int MAX_BEATS = MAX_BEATS_DEF,
  localparam int ACC_W     = PIX_W + clog2(LANES) + clog2(MAX_BEATS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  input  logic [LANES*PIX_W-1:0] a_pix,
  input  logic [LANES*PIX_W-1:0] b_pix,
  output logic                   sad_valid,
  input  logic                   sad_ready,
  output logic [ACC_W-1:0]       sad_out,
  output logic                   sad_ovf
);
  localparam int PW     = LANES * PIX_W;
  localparam int LEVELS = clog2(LANES) - 1;
  // Each 4:2 row adds two bits of headroom; the tree runs at its final width.
  localparam int TW     = PIX_W + 2 * LEVELS;
  localparam int NODES  = 2 * LANES - 2;
  localparam int CNT_W  = clog2(MAX_BEATS);

  logic stall, fire;
  assign stall    = sad_valid & ~sad_ready;
  assign in_ready = rst_n & ~stall;
  assign fire     = in_valid & in_ready;

  // Beat counter: the MAX_BEATS-th beat closes the block even without in_last.
  logic [CNT_W-1:0] beat_cnt;
  logic             cnt_full, blk_last, blk_ovf;
  assign cnt_full = (beat_cnt == CNT_W'(MAX_BEATS - 1));
  assign blk_last = in_last | cnt_full;
  assign blk_ovf  = ~in_last & cnt_full;

  // S0
  logic          s0_valid, s0_last, s0_ovf;
  logic [PW-1:0] s0_a, s0_b;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      s0_valid <= 1'b0;
      s0_last  <= 1'b0;
      s0_ovf   <= 1'b0;
      s0_a     <= '0;
      s0_b     <= '0;
    end else if (!stall) begin
      s0_valid <= fire;
      s0_last  <= blk_last;
      s0_ovf   <= blk_ovf;
      s0_a     <= a_pix;
      s0_b     <= b_pix;
      if (fire) beat_cnt <= blk_last ? '0 : beat_cnt + 1'b1;
    end
  end

  // S1
  logic [PIX_W-1:0] abs_d   [LANES];
  logic [PIX_W-1:0] s1_diff [LANES];
  logic             s1_valid, s1_last, s1_ovf;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [PIX_W-1:0] pa, pb;
    assign pa       = s0_a[lane_lo(i, PIX_W) +: PIX_W];
    assign pb       = s0_b[lane_lo(i, PIX_W) +: PIX_W];
    assign abs_d[i] = (pa >= pb) ? (pa - pb) : (pb - pa);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_ovf   <= 1'b0;
      s1_diff  <= '{default: '0};
    end else if (!stall) begin
      s1_valid <= s0_valid;
      s1_last  <= s0_last;
      s1_ovf   <= s0_ovf;
      s1_diff  <= abs_d;
    end
  end

  // S2: nodes [0, LANES) hold the lane differences; each tree level appends
  // its outputs after the previous level's, ending in the final sum/carry pair.
  logic [TW-1:0] node [NODES];
  logic [TW-1:0] tree_s, tree_c;
  logic          s2_valid, s2_last, s2_ovf;

  for (genvar i = 0; i < LANES; i++) begin : g_leaf
    assign node[i] = TW'(s1_diff[i]);
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    for (genvar r = 0; r < (LANES >> l) / 4; r++) begin : g_row
      localparam int IB = 2 * LANES - 2 * (LANES >> l) + 4 * r;
      localparam int OB = 2 * LANES - 2 * (LANES >> (l + 1)) + 2 * r;
      csa_4_2_row #(.W(TW)) u_row (
        .x1   (node[IB]),
        .x2   (node[IB+1]),
        .x3   (node[IB+2]),
        .x4   (node[IB+3]),
        .sum  (node[OB]),
        .carry(node[OB+1])
      );
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_ovf   <= 1'b0;
      tree_s   <= '0;
      tree_c   <= '0;
    end else if (!stall) begin
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      s2_ovf   <= s1_ovf;
      tree_s   <= node[NODES-2];
      tree_c   <= node[NODES-1];
    end
  end

  // S3: acc_done marks that acc holds a finished block, so the next beat
  // (even after bubbles) starts from zero while S4 still reads the total.
  logic [ACC_W-1:0] acc_s, acc_c, base_s, base_c, nxt_s, nxt_c;
  logic             acc_done, s3_last, s3_ovf;

  assign base_s = acc_done ? '0 : acc_s;
  assign base_c = acc_done ? '0 : acc_c;

  csa_4_2_row #(.W(ACC_W)) u_acc (
    .x1   (ACC_W'(tree_s)),
    .x2   (ACC_W'(tree_c)),
    .x3   (base_s),
    .x4   (base_c),
    .sum  (nxt_s),
    .carry(nxt_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_s    <= '0;
      acc_c    <= '0;
      acc_done <= 1'b0;
      s3_last  <= 1'b0;
      s3_ovf   <= 1'b0;
    end else if (!stall) begin
      s3_last <= s2_valid & s2_last;
      s3_ovf  <= s2_ovf;
      if (s2_valid) begin
        acc_s    <= nxt_s;
        acc_c    <= nxt_c;
        acc_done <= s2_last;
      end
    end
  end

  // S4: a new result may overwrite one transferring on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sad_valid <= 1'b0;
      sad_out   <= '0;
      sad_ovf   <= 1'b0;
    end else if (!stall) begin
      if (s3_last) begin
        sad_valid <= 1'b1;
        sad_out   <= acc_s + acc_c;
        sad_ovf   <= s3_ovf;
      end else begin
        sad_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sad_csa_accum_pipe.sv
// Directed bench for sad_csa_accum_pipe (PIX_W=8, LANES=8, MAX_BEATS=4).
module tb_sad_csa_accum_pipe;
  localparam int PIX_W     = 8;
  localparam int LANES     = 8;
  localparam int MAX_BEATS = 4;
  localparam int ACC_W     = 13;
  localparam int PW        = LANES * PIX_W;
  localparam int EXP_W     = ACC_W + 1;

  logic             clk = 1'b0;
  logic             rst_n, in_valid, in_ready, in_last;
  logic [PW-1:0]    a_pix, b_pix;
  logic             sad_valid, sad_ready, sad_ovf;
  logic [ACC_W-1:0] sad_out;

  sad_csa_accum_pipe #(.PIX_W(PIX_W), .LANES(LANES), .MAX_BEATS(MAX_BEATS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_last  (in_last),
    .a_pix    (a_pix),
    .b_pix    (b_pix),
    .sad_valid(sad_valid),
    .sad_ready(sad_ready),
    .sad_out  (sad_out),
    .sad_ovf  (sad_ovf)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int               n_tests = 0;
  int               n_fail  = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] exp_e;
  int               res_cyc_prev = -1;
  int               res_cyc_last = -1;
  int               acc_cyc = 0;
  logic             prev_stall = 1'b0;
  logic [ACC_W-1:0] prev_out;
  logic             prev_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (prev_stall) begin
        check("hold_valid", sad_valid, 1);
        check("hold_out", sad_out, prev_out);
        check("hold_ovf", sad_ovf, prev_ovf);
      end
      if (sad_valid && !sad_ready) check("stall_in_ready", in_ready, 0);
      if (sad_valid && sad_ready) begin
        check("result_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          exp_e = exp_q.pop_front();
          check("sad_out", sad_out, exp_e[ACC_W-1:0]);
          check("sad_ovf", sad_ovf, exp_e[ACC_W]);
        end
        res_cyc_prev = res_cyc_last;
        res_cyc_last = cyc;
      end
      prev_stall = sad_valid && !sad_ready;
      prev_out   = sad_out;
      prev_ovf   = sad_ovf;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // driver tasks
  function automatic logic [PW-1:0] fill(input logic [PIX_W-1:0] v);
    logic [PW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*PIX_W +: PIX_W] = v;
    return r;
  endfunction

  function automatic logic [PW-1:0] ramp(input int step);
    logic [PW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*PIX_W +: PIX_W] = PIX_W'(step * i);
    return r;
  endfunction

  task automatic send_beat(input logic [PW-1:0] a, input logic [PW-1:0] b, input logic last);
    int n;
    n        = 0;
    a_pix    = a;
    b_pix    = b;
    in_last  = last;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check("in_ready_timeout", in_ready, 1);
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    int n, t0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    a_pix     = '0;
    b_pix     = '0;
    sad_ready = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sad_valid", sad_valid, 0);
    check("rst_sad_out", sad_out, 0);
    check("rst_sad_ovf", sad_ovf, 0);
    check("rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // single beat, full-scale differences, plus latency
    exp_q.push_back({1'b0, 13'd2040});
    send_beat(fill(8'd255), fill(8'd0), 1'b1);
    t0 = acc_cyc;
    n  = 0;
    @(negedge clk);
    while (!sad_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("latency", cyc - t0, 5);
    drain("drain_single");

    // a < b on every lane
    exp_q.push_back({1'b0, 13'd1576});
    send_beat(fill(8'd3), fill(8'd200), 1'b1);
    drain("drain_mixed");

    // 4-beat block followed immediately by a zero block
    exp_q.push_back({1'b0, 13'd1120});
    exp_q.push_back({1'b0, 13'd0});
    for (int k = 0; k < 4; k++) send_beat(ramp(10), fill(8'd0), k == 3);
    send_beat(fill(8'd77), fill(8'd77), 1'b1);
    drain("drain_4beat");
    check("back_to_back", res_cyc_last - res_cyc_prev, 1);

    // backpressure: 2-beat blocks while the first result is refused
    exp_q.push_back({1'b0, 13'd56});
    exp_q.push_back({1'b0, 13'd800});
    exp_q.push_back({1'b0, 13'd16});
    exp_q.push_back({1'b0, 13'd160});
    sad_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 2; k++) send_beat(ramp(1), fill(8'd0), k == 1);
        for (int k = 0; k < 2; k++) send_beat(fill(8'd0), fill(8'd50), k == 1);
        for (int k = 0; k < 2; k++) send_beat(fill(8'd255), fill(8'd254), k == 1);
        for (int k = 0; k < 2; k++) send_beat(fill(8'd100), fill(8'd90), k == 1);
      end
      begin
        int m;
        m = 0;
        @(negedge clk);
        while (!sad_valid && m < 40) begin
          m++;
          @(negedge clk);
        end
        check("bp_first_valid", sad_valid, 1);
        repeat (5) @(posedge clk);
        #1 sad_ready = 1'b1;
      end
    join
    drain("drain_backpressure");

    // forced block end at MAX_BEATS
    exp_q.push_back({1'b1, 13'd32});
    exp_q.push_back({1'b0, 13'd16});
    for (int k = 0; k < 6; k++) send_beat(fill(8'd1), fill(8'd0), k == 5);
    drain("drain_overflow");

    // reset in the middle of a block
    send_beat(fill(8'd5), fill(8'd0), 1'b0);
    send_beat(fill(8'd5), fill(8'd0), 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_valid_pre", sad_valid, 0);
    @(posedge clk);
    @(negedge clk);
    check("midrst_valid", sad_valid, 0);
    check("midrst_out", sad_out, 0);
    check("midrst_ovf", sad_ovf, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back({1'b0, 13'd8});
    send_beat(fill(8'd1), fill(8'd0), 1'b1);
    drain("drain_reset");

    repeat (5) @(posedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sad_csa_accum_pipe.md
Name: sad_csa_accum_pipe

Overview:
- Pipelined sum-of-absolute-differences engine for block matching.
- Each beat carries LANES pixel pairs. It forms |a-b| per lane and reduces the lanes through a tree of 4:2 compressor rows.
- The block total is accumulated in carry-save form across beats, with one carry-propagate add at block end.
- Sits between the pixel fetch stream and the motion-search comparator; replaces per-beat ripple adders.

Parameters:
- PIX_W, 8, pixel width in bits.
- LANES, 8, pixel pairs per beat; power of two, at least 4.
- MAX_BEATS, 256, maximum beats per block; power of two.
- ACC_W, PIX_W+clog2(LANES)+clog2(MAX_BEATS), derived accumulator/result width; not overridable.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_last  in  1  final beat of the current block.
- a_pix  in  LANES*PIX_W  current-block pixels, lane i at bits [i*PIX_W +: PIX_W], unsigned.
- b_pix  in  LANES*PIX_W  reference pixels, same packing.
- sad_valid  out  1  result valid.
- sad_ready  in  1  downstream accepts the result.
- sad_out  out  ACC_W  block SAD, unsigned.
- sad_ovf  out  1  block was force-terminated at MAX_BEATS.

Behaviour:
- Reset (rst_n low at a clk edge): clear all stage valids, accumulator sum/carry vectors, beat counter, sad_valid, sad_out and sad_ovf to 0. Any partial block in flight is discarded.
- in_ready is 0 during reset.
- Stall: stall = sad_valid && !sad_ready. in_ready = !stall. When stall is high, every pipeline register holds.
- S1, absolute difference: registers |a_i - b_i| per lane (PIX_W bits, unsigned), plus valid and last.
- S2, compressor tree: reduces LANES values through 4:2 rows to a redundant sum/carry pair, registered.
  - Row widths grow so that no bit is dropped.
  - Each row's cin chain enters at bit 0 as 0.
- S3, carry-save accumulate: one 4:2 row combines tree sum, tree carry, acc_s and acc_c into new acc_s/acc_c, ACC_W bits.
  - On the first beat of a block, acc_s/acc_c are taken as 0.
- S4, output: on the last beat, CPA(acc_s+acc_c) goes to sad_out, sad_valid is set and acc clears.
  - A beat following the last beat starts a new block with no bubble.
- Latency: a last beat accepted at edge t gives sad_valid=1 after edge t+4, with no stalls. Throughput is one beat per cycle.
- Beat counter:
  - Counts accepted beats of the current block.
  - If beat MAX_BEATS arrives without in_last, it is treated as last and that result carries sad_ovf=1.
  - The next beat begins a fresh block.
- sad_valid and sad_out stay stable until the sad_ready handshake completes.
  - sad_valid falls the cycle after the handshake unless a new result is produced in that same cycle.
  - A new result in that cycle replaces the old one with no gap.
- sad_ready may be high while sad_valid is low; this has no effect.
- Arithmetic is exact for up to MAX_BEATS beats; the maximum sum fits ACC_W bits.

Decomposition:
- Shared package sad_pkg holds:
  - the clog2 function
  - default PIX_W/LANES/MAX_BEATS constants
  - the packed-lane slice helper, so the fetch and comparator blocks use identical packing.
- Sub-module csa_4_2_row (parameter W): W instances of the existing single-bit 4:2 compressor cell, with the carry-out chain wired intercell.
  - Used both in the tree and in the accumulator.

Test Plan:
- Single-beat block: a=all 255, b=all 0, in_last=1, sad_ready=1. Expect sad_out=2040, sad_ovf=0, sad_valid four cycles after acceptance.
- Mixed sign: lane i a=3, b=200 on every lane, 1 beat. Expect sad_out=1576 (197*8).
- 4-beat block: lane i a=10*i, b=0, in_last on beat 4, then an immediate second 1-beat block with a=b. Expect 1120 then 0, on consecutive cycles.
- Backpressure:
  - Stimulus: back-to-back 2-beat blocks with sad_ready held low for 5 cycles after the first result.
  - Expect in_ready=0 during the stall, sad_out held and stable, no beat lost.
  - Second result correct after release.
- Overflow: MAX_BEATS=4, 6 beats of all-1 differences with in_last only on beat 6.
  - Expect 32 with sad_ovf=1.
  - Then 16 with sad_ovf=0.
- Reset mid-block:
  - Stimulus: 2 beats of diff 5, rst_n low for one cycle, then 1 beat of diff 1 with in_last.
  - Expect sad_out=8; the first 2 beats contribute nothing.
  - Expect sad_valid=0 throughout reset.
